// File: rtl/aud_recorder_if.sv
// Signal bundle between the I2S ADC/control side and the audio recorder.
// The slave modport is the recorder's view; master is the driving side.
interface aud_recorder_if;
    logic        i_lrc;
    logic        i_data;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;
    logic [19:0] o_address;
    logic [15:0] o_data;
    logic        o_we_n;
    logic        o_recording;
    logic        o_done;
    logic [20:0] o_count;

    modport master (
        output i_lrc, i_data, i_start, i_pause, i_stop,
        input  o_address, o_data, o_we_n, o_recording, o_done, o_count
    );

    modport slave (
        input  i_lrc, i_data, i_start, i_pause, i_stop,
        output o_address, o_data, o_we_n, o_recording, o_done, o_count
    );
endinterface

// File: rtl/aud_recorder.sv
// Captures the left channel of an I2S ADC stream and writes one 16-bit sample
// per LRC frame to sequential SRAM addresses, with start/pause/stop control.
module aud_recorder #(
    parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    aud_recorder_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFrame,
        StCapture,
        StStore,
        StPaused,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        lrc_q;
    logic [14:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [20:0] count_q, count_d;
    logic [15:0] data_q, data_d;

    logic frame_start;
    logic stop_cmd, pause_cmd, start_cmd;

    assign frame_start = lrc_q & ~bus.i_lrc;

    // Only the highest-priority pulse of a cycle is acted upon.
    assign stop_cmd  = bus.i_stop;
    assign pause_cmd = ~bus.i_stop & bus.i_pause;
    assign start_cmd = ~bus.i_stop & ~bus.i_pause & bus.i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            lrc_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            lrc_q     <= bus.i_lrc;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        count_d   = count_q;
        data_d    = data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_cmd) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = StWaitFrame;
                end
            end
            StWaitFrame: begin
                if (stop_cmd) begin
                    state_d = StDone;
                end else if (pause_cmd) begin
                    state_d = StPaused;
                end else if (frame_start) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (stop_cmd) begin
                    state_d = StDone;
                end else if (pause_cmd) begin
                    state_d = StPaused;
                end else begin
                    shift_d   = {shift_q[13:0], bus.i_data};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        data_d  = {shift_q, bus.i_data};
                        state_d = StStore;
                    end
                end
            end
            StStore: begin
                // The write always completes; pulses only choose the next state.
                count_d = count_q + 21'd1;
                if (addr_q != MAX_ADDR) begin
                    addr_d = addr_q + 20'd1;
                end
                if (stop_cmd || addr_q == MAX_ADDR) begin
                    state_d = StDone;
                end else if (pause_cmd) begin
                    state_d = StPaused;
                end else begin
                    state_d = StWaitFrame;
                end
            end
            StPaused: begin
                if (stop_cmd) begin
                    state_d = StDone;
                end else if (start_cmd) begin
                    state_d = StWaitFrame;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.o_address   = addr_q;
    assign bus.o_data      = data_q;
    assign bus.o_count     = count_q;
    assign bus.o_we_n      = (state_q != StStore);
    assign bus.o_recording = (state_q == StWaitFrame) || (state_q == StCapture) ||
                             (state_q == StStore);
    assign bus.o_done      = (state_q == StDone);

endmodule
